// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

    localparam int          PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and req/gnt/rvalid fetch FSM with branch redirect
// Optional misaligned-redirect fault output enabled by FETCH_MISALIGN_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic              fetch_fault,
`endif
    input  logic              clk,
    input  logic              reset,
    input  logic              en_fetch,
    input  logic              en_branch,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              done,
    output logic              branch,
    output logic              busy
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              branch_q, branch_d;
    logic              drop_q, drop_d;
    logic              fault_q, fault_d;
    logic              redirect;

    assign redirect = en_branch && br_taken;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        branch_d   = branch_q;
        drop_d     = drop_q;
        fault_d    = fault_q;

        // The FSM's first en_fetch after a redirect only acknowledges it.
        if (en_fetch && branch_q && !fault_q) begin
            branch_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (en_fetch && !branch_q && !en_branch && !fault_q) begin
                    state_d = S_REQ;
                    addr_d  = pc_q;
                    valid_d = 1'b0;
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                    if (!drop_q) begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        done_d     = 1'b1;
                        pc_d       = pc_q + ADDR_W'(PC_INCR);
                    end else begin
                        drop_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect landing on the very cycle data returns wins over that data.
        if (redirect) begin
            branch_d = 1'b1;
            pc_d     = br_target;
            valid_d  = 1'b0;
            done_d   = 1'b0;
            drop_d   = (state_q == S_REQ) || ((state_q == S_WAIT) && !imem_rvalid);
`ifdef FETCH_MISALIGN_CHECK_EN
            if (br_target[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            branch_q   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            branch_q   <= branch_d;
            drop_q     <= drop_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fetch_fault = fault_q;
`else
    assign fault_q = 1'b0;
`endif

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign branch      = branch_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        en_fetch;
    logic        en_branch;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        done;
    logic        branch;
    logic        busy;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_fault (fetch_fault),
`endif
        .clk         (clk),
        .reset       (reset),
        .en_fetch    (en_fetch),
        .en_branch   (en_branch),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .done        (done),
        .branch      (branch),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory responder: grant after gnt_dly idle request cycles, data rv_dly cycles after grant.
    int          gnt_dly = 0;
    int          rv_dly  = 1;
    int          gcnt    = 0;
    int          rcnt    = 0;
    int          ngnt    = 0;
    bit          pending = 0;
    bit          unstable = 0;
    logic [31:0] lat_addr = '0;
    logic [31:0] first_addr = '0;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (pending) begin
                rcnt--;
                if (rcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(lat_addr);
                    pending     = 0;
                end
            end else if (imem_req) begin
                if (gcnt == 0) first_addr = imem_addr;
                else if (imem_addr !== first_addr) unstable = 1;
                if (gcnt == gnt_dly) begin
                    imem_gnt = 1'b1;
                    lat_addr = imem_addr;
                    pending  = 1;
                    rcnt     = rv_dly;
                    gcnt     = 0;
                    ngnt++;
                end else begin
                    gcnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fetch(output int nd, output int nb);
        en_fetch = 1'b1;
        tick();
        en_fetch = 1'b0;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (!busy) break;
            tick();
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        en_branch = 1'b1;
        br_taken  = 1'b1;
        br_target = tgt;
        tick();
        en_branch = 1'b0;
        br_taken  = 1'b0;
    endtask

    int nd, nb, g0;

    initial begin
        reset = 1'b0; en_fetch = 1'b0; en_branch = 1'b0; br_taken = 1'b0; br_target = '0;
        tick(); tick();
        check("rst_valid", instr_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_branch", branch, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        reset = 1'b1;
        tick();

        // zero-wait memory
        gnt_dly = 0; rv_dly = 1;
        run_fetch(nd, nb);
        check("zw_done", nd, 1);
        check("zw_busy", nb, 2);
        check("zw_addr", lat_addr, 32'h0);
        check("zw_instr", instr, 32'hDEAD_0000);
        check("zw_pc", instr_pc, 32'h0);
        check("zw_valid", instr_valid, 1'b1);
        tick();
        check("zw_done_pulse", done, 1'b0);
        run_fetch(nd, nb);
        check("zw2_addr", lat_addr, 32'h4);
        check("zw2_instr", instr, 32'hDEAD_0004);
        check("zw2_pc", instr_pc, 32'h4);

        // slow memory
        gnt_dly = 2; rv_dly = 2; unstable = 0;
        run_fetch(nd, nb);
        check("slow_done", nd, 1);
        check("slow_busy", nb, 5);
        check("slow_addr", lat_addr, 32'h8);
        check("slow_stable", unstable, 1'b0);
        check("slow_pc", instr_pc, 32'h8);

        // redirect while idle
        gnt_dly = 0; rv_dly = 1;
        redirect(32'h100);
        check("br_set", branch, 1'b1);
        check("br_valid", instr_valid, 1'b0);
        g0 = ngnt;
        run_fetch(nd, nb);
        check("br_clear", branch, 1'b0);
        check("br_noreq", ngnt - g0, 0);
        check("br_nobusy", nb, 0);
        run_fetch(nd, nb);
        check("br_addr", lat_addr, 32'h100);
        check("br_instr", instr, 32'hDEAD_0100);

        // not-taken resolution has no effect
        en_branch = 1'b1; br_taken = 1'b0; br_target = 32'h500;
        tick();
        en_branch = 1'b0;
        check("nt_branch", branch, 1'b0);
        check("nt_valid", instr_valid, 1'b1);

        // redirect while waiting for data
        rv_dly = 3;
        en_fetch = 1'b1; tick(); en_fetch = 1'b0;
        tick();
        check("rw_busy", busy, 1'b1);
        redirect(32'h200);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) nd++;
            if (!busy) break;
            tick();
        end
        check("rw_busy_end", busy, 1'b0);
        check("rw_nodone", nd, 0);
        check("rw_valid", instr_valid, 1'b0);
        check("rw_branch", branch, 1'b1);
        rv_dly = 1;
        run_fetch(nd, nb);
        run_fetch(nd, nb);
        check("rw_addr", lat_addr, 32'h200);
        check("rw_pc", instr_pc, 32'h200);
        check("rw_done", nd, 1);

        // en_fetch and en_branch together
        g0 = ngnt;
        en_fetch = 1'b1; en_branch = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        tick();
        en_fetch = 1'b0; en_branch = 1'b0; br_taken = 1'b0;
        check("same_req", imem_req, 1'b0);
        check("same_branch", branch, 1'b1);
        tick();
        check("same_nogrant", ngnt - g0, 0);
        run_fetch(nd, nb);
        run_fetch(nd, nb);
        check("same_addr", lat_addr, 32'h40);
        check("same_instr", instr, 32'hDEAD_0040);

        // second redirect overwrites the first
        redirect(32'h300);
        redirect(32'h80);
        run_fetch(nd, nb);
        run_fetch(nd, nb);
        check("dbl_addr", lat_addr, 32'h80);

        // pc wraps modulo 2^32
        redirect(32'hFFFF_FFFC);
        run_fetch(nd, nb);
        run_fetch(nd, nb);
        check("wrap_addr", lat_addr, 32'hFFFF_FFFC);
        check("wrap_instr", instr, 32'h2152_FFFC);
        run_fetch(nd, nb);
        check("wrap_next", lat_addr, 32'h0);

        // reset in S_WAIT, stray rvalid afterwards
        rv_dly = 6;
        en_fetch = 1'b1; tick(); en_fetch = 1'b0;
        tick();
        check("rsw_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rsw_idle", busy, 1'b0);
        check("rsw_req", imem_req, 1'b0);
        tick();
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) nd++;
        end
        check("rsw_stray", nd, 0);
        check("rsw_stray_valid", instr_valid, 1'b0);
        rv_dly = 1;
        run_fetch(nd, nb);
        check("rsw_addr", lat_addr, 32'h0);
        check("rsw_done", nd, 1);

`ifdef FETCH_MISALIGN_CHECK_EN
        check("flt_reset", fetch_fault, 1'b0);
        redirect(32'h102);
        check("flt_set", fetch_fault, 1'b1);
        g0 = ngnt;
        run_fetch(nd, nb);
        run_fetch(nd, nb);
        check("flt_nofetch", ngnt - g0, 0);
        check("flt_sticky", fetch_fault, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
